// File: rtl/instr_encoder.sv
// instr_encoder: turns decoded MIPS operation descriptors (class, register fields, funct,
// immediate) back into 32-bit instruction words, each tagged with an incrementing
// instruction-memory word address. Intended as a program loader that fills instruction
// memory for the reference cores.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset
//   start_i      one-cycle pulse: address counter := BASE_ADDR, error count := 0
//   in_valid_i   descriptor valid
//   in_ready_o   descriptor accepted when in_valid_i & in_ready_o
//   in_class_i   00 R-type, 01 lw, 10 sw, 11 beq
//   in_rs_i      source register
//   in_rt_i      second source / load destination
//   in_rd_i      R-type destination
//   in_funct_i   R-type function code
//   in_imm_i     16-bit offset for lw/sw/beq
//   out_valid_o  instruction word valid
//   out_ready_i  consumer ready
//   out_instr_o  encoded instruction (head of the 2-entry buffer)
//   out_addr_o   word address of out_instr_o
//   err_pulse_o  one-cycle pulse: an illegal descriptor was dropped
//   err_count_o  saturating count of dropped descriptors
module instr_encoder #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [1:0]        in_class_i,
  input  logic [4:0]        in_rs_i,
  input  logic [4:0]        in_rt_i,
  input  logic [4:0]        in_rd_i,
  input  logic [5:0]        in_funct_i,
  input  logic [15:0]       in_imm_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       out_instr_o,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic              err_pulse_o,
  output logic [7:0]        err_count_o
);

  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);

  logic [31:0]       mem_q [2];
  logic              rd_ptr_q, wr_ptr_q;
  logic [1:0]        count_q, count_d;
  logic [ADDR_W-1:0] addr_q;
  logic              err_pulse_q;
  logic [7:0]        err_count_q;

  logic        legal;
  logic [31:0] enc_instr;
  logic        accept, push, pop, drop;

  // Encoder and legality check.
  always_comb begin
    enc_instr = 32'h0;
    legal     = 1'b1;
    unique case (in_class_i)
      2'b00: begin
        enc_instr = {6'b000000, in_rs_i, in_rt_i, in_rd_i, 5'b00000, in_funct_i};
        unique case (in_funct_i)
          6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: legal = 1'b1;
          default:                                               legal = 1'b0;
        endcase
      end
      2'b01: enc_instr = {6'b100011, in_rs_i, in_rt_i, in_imm_i};
      2'b10: enc_instr = {6'b101011, in_rs_i, in_rt_i, in_imm_i};
      2'b11: enc_instr = {6'b000100, in_rs_i, in_rt_i, in_imm_i};
      default: enc_instr = 32'h0;
    endcase
  end

  // Ready depends only on the occupancy register, never on in_* or out_ready_i.
  assign in_ready_o  = (count_q != 2'd2);
  assign out_valid_o = (count_q != 2'd0);
  assign out_instr_o = mem_q[rd_ptr_q];
  assign out_addr_o  = addr_q;
  assign err_pulse_o = err_pulse_q;
  assign err_count_o = err_count_q;

  // Illegal descriptors complete the handshake but never enter the buffer.
  assign accept = in_valid_i & in_ready_o;
  assign push   = accept & legal;
  assign drop   = accept & ~legal;
  assign pop    = out_valid_o & out_ready_i;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q[0]    <= 32'h0;
      mem_q[1]    <= 32'h0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      addr_q      <= BaseAddr;
      err_pulse_q <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= enc_instr;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q     <= count_d;
      err_pulse_q <= drop;
      // start overrides both a concurrent pop and a concurrent drop.
      if (start_i) begin
        err_count_q <= 8'd0;
      end else if (drop && (err_count_q != 8'hFF)) begin
        err_count_q <= err_count_q + 8'd1;
      end
      if (start_i) begin
        addr_q <= BaseAddr;
      end else if (pop) begin
        addr_q <= addr_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, in_ready, out_valid, out_ready, err_pulse;
  logic [1:0]    in_class;
  logic [4:0]    in_rs, in_rt, in_rd;
  logic [5:0]    in_funct;
  logic [15:0]   in_imm;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;
  logic [7:0]    err_count;

  int n_chk = 0;
  int n_err = 0;

  // Scoreboard state.
  logic [31:0] exp_q[$];
  int          exp_addr = 0;
  bit          exp_err_pulse = 0;
  int          exp_err_cnt = 0;

  instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_class_i (in_class),
    .in_rs_i    (in_rs),
    .in_rt_i    (in_rt),
    .in_rd_i    (in_rd),
    .in_funct_i (in_funct),
    .in_imm_i   (in_imm),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_instr_o(out_instr),
    .out_addr_o (out_addr),
    .err_pulse_o(err_pulse),
    .err_count_o(err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_enc(input logic [1:0] c, input logic [4:0] rs,
                                            input logic [4:0] rt, input logic [4:0] rd,
                                            input logic [5:0] f, input logic [15:0] imm);
    case (c)
      2'd0:    return {6'h00, rs, rt, rd, 5'h00, f};
      2'd1:    return {6'h23, rs, rt, imm};
      2'd2:    return {6'h2B, rs, rt, imm};
      default: return {6'h04, rs, rt, imm};
    endcase
  endfunction

  function automatic bit model_legal(input logic [1:0] c, input logic [5:0] f);
    if (c != 2'd0) return 1'b1;
    return (f == 6'h20) || (f == 6'h22) || (f == 6'h24) || (f == 6'h25) || (f == 6'h2A);
  endfunction

  // Scoreboard monitor: compares the DUT state against the model every cycle, then
  // advances the model by what happens at the next rising edge.
  always @(negedge clk) begin
    bit hs;
    if (rst) begin
      exp_q.delete();
      exp_addr      = 0;
      exp_err_pulse = 0;
      exp_err_cnt   = 0;
    end else begin
      n_chk++;
      if (out_valid !== (exp_q.size() > 0)) begin
        n_err++;
        $display("FAIL sb_out_valid t=%0t got %b want %b", $time, out_valid, exp_q.size() > 0);
      end
      n_chk++;
      if (in_ready !== (exp_q.size() < 2)) begin
        n_err++;
        $display("FAIL sb_in_ready t=%0t got %b want %b", $time, in_ready, exp_q.size() < 2);
      end
      n_chk++;
      if (out_addr !== AW'(exp_addr)) begin
        n_err++;
        $display("FAIL sb_out_addr t=%0t got %0d want %0d", $time, out_addr, exp_addr);
      end
      n_chk++;
      if (err_pulse !== exp_err_pulse) begin
        n_err++;
        $display("FAIL sb_err_pulse t=%0t got %b want %b", $time, err_pulse, exp_err_pulse);
      end
      n_chk++;
      if (err_count !== 8'(exp_err_cnt)) begin
        n_err++;
        $display("FAIL sb_err_count t=%0t got %0d want %0d", $time, err_count, exp_err_cnt);
      end
      if (exp_q.size() > 0) begin
        n_chk++;
        if (out_instr !== exp_q[0]) begin
          n_err++;
          $display("FAIL sb_out_instr t=%0t got %h want %h", $time, out_instr, exp_q[0]);
        end
      end
      // Advance model across the coming edge.
      hs = (exp_q.size() > 0) && out_ready;
      exp_err_pulse = 0;
      if (hs) void'(exp_q.pop_front());
      if (in_valid && in_ready) begin
        if (model_legal(in_class, in_funct)) begin
          exp_q.push_back(model_enc(in_class, in_rs, in_rt, in_rd, in_funct, in_imm));
        end else begin
          exp_err_pulse = 1;
          if (exp_err_cnt < 255) exp_err_cnt++;
        end
      end
      if (start) begin
        exp_addr    = 0;
        exp_err_cnt = 0;
      end else if (hs) begin
        exp_addr = (exp_addr + 1) % (1 << AW);
      end
    end
  end

  task automatic set_desc(input logic [1:0] c, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [5:0] f, input logic [15:0] imm);
    in_valid = 1'b1;
    in_class = c;
    in_rs    = rs;
    in_rt    = rt;
    in_rd    = rd;
    in_funct = f;
    in_imm   = imm;
  endtask

  // Presents a descriptor and returns just after the edge that accepted it.
  task automatic send(input logic [1:0] c, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [5:0] f, input logic [15:0] imm);
    int waited = 0;
    set_desc(c, rs, rt, rd, f, imm);
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    n_chk++;
    if (!in_ready) begin
      n_err++;
      $display("FAIL send_timeout t=%0t got in_ready=%b want 1", $time, in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({in_ready, out_valid, err_pulse} !== 3'b100 || out_instr !== 32'h0 ||
        out_addr !== '0 || err_count !== 8'h0) begin
      n_err++;
      $display("FAIL reset_state got rdy=%b vld=%b ep=%b instr=%h addr=%0d ec=%0d want 1 0 0 0 0 0",
               in_ready, out_valid, err_pulse, out_instr, out_addr, err_count);
    end
  endtask

  task automatic test_lw();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(2'd1, 5'd2, 5'd3, 5'd0, 6'd0, 16'h0010);
    idle();
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b1 || out_instr !== 32'h8C430010 || out_addr !== 8'd0) begin
      n_err++;
      $display("FAIL lw_word got vld=%b instr=%h addr=%0d want 1 8c430010 0",
               out_valid, out_instr, out_addr);
    end
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL lw_drain got vld=%b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    pulse_start();
    send(2'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0);
    send(2'd2, 5'd4, 5'd5, 5'd0, 6'h0, 16'hFFFC);
    idle();
    repeat (2) begin
      @(negedge clk);
      n_chk++;
      if (in_ready !== 1'b0 || out_instr !== 32'h00221820) begin
        n_err++;
        $display("FAIL bp_hold got rdy=%b instr=%h want 0 00221820", in_ready, out_instr);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if (out_instr !== 32'h00221820 || out_addr !== 8'd0) begin
      n_err++;
      $display("FAIL bp_first got %h@%0d want 00221820@0", out_instr, out_addr);
    end
    @(negedge clk);
    n_chk++;
    if (out_instr !== 32'hAC85FFFC || out_addr !== 8'd1) begin
      n_err++;
      $display("FAIL bp_second got %h@%0d want ac85fffc@1", out_instr, out_addr);
    end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    pulse_start();
    send(2'd3, 5'd1, 5'd0, 5'd0, 6'h0, 16'hFFFF);
    set_desc(2'd0, 5'd1, 5'd2, 5'd3, 6'b000111, 16'h0);
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b1 || out_instr !== 32'h1020FFFF) begin
      n_err++;
      $display("FAIL beq_word got vld=%b instr=%h want 1 1020ffff", out_valid, out_instr);
    end
    @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    n_chk++;
    if (err_pulse !== 1'b1 || err_count !== 8'd1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL illegal_drop got ep=%b ec=%0d vld=%b want 1 1 0",
               err_pulse, err_count, out_valid);
    end
    @(negedge clk);
    n_chk++;
    if (err_pulse !== 1'b0) begin
      n_err++;
      $display("FAIL illegal_pulse_len got ep=%b want 0", err_pulse);
    end
  endtask

  task automatic test_stream();
    logic [5:0] legal_f [5];
    legal_f = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    out_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 257; i++) begin
      logic [1:0] c;
      c = 2'($urandom_range(0, 3));
      set_desc(c, 5'($urandom), 5'($urandom), 5'($urandom),
               legal_f[$urandom_range(0, 4)], 16'($urandom));
      @(negedge clk);
      if (i > 0) begin
        n_chk++;
        if (out_valid !== 1'b1 || out_addr !== AW'(i - 1) || in_ready !== 1'b1) begin
          n_err++;
          $display("FAIL stream_rate i=%0d got vld=%b addr=%0d rdy=%b want 1 %0d 1",
                   i, out_valid, out_addr, in_ready, (i - 1) % 256);
        end
      end
      @(posedge clk);
      #1;
    end
    idle();
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b1 || out_addr !== 8'd0) begin
      n_err++;
      $display("FAIL stream_wrap got vld=%b addr=%0d want 1 0", out_valid, out_addr);
    end
    @(negedge clk);
  endtask

  task automatic test_saturate();
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      set_desc(2'd0, 5'd1, 5'd1, 5'd1, 6'h3F, 16'h0);
      @(posedge clk);
      #1;
    end
    idle();
    @(negedge clk);
    n_chk++;
    if (err_count !== 8'd255) begin
      n_err++;
      $display("FAIL err_saturate got %0d want 255", err_count);
    end
    @(posedge clk);
    #1;
    pulse_start();
    @(negedge clk);
    n_chk++;
    if (err_count !== 8'd0 || out_addr !== 8'd0) begin
      n_err++;
      $display("FAIL start_clear got ec=%0d addr=%0d want 0 0", err_count, out_addr);
    end
    @(posedge clk);
    #1;
    send(2'd1, 5'd7, 5'd8, 5'd0, 6'h0, 16'h1234);
    idle();
    @(negedge clk);
    n_chk++;
    if (out_instr !== 32'h8CE81234 || out_addr !== 8'd0) begin
      n_err++;
      $display("FAIL start_next_word got %h@%0d want 8ce81234@0", out_instr, out_addr);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    send(2'd0, 5'd9, 5'd10, 5'd11, 6'h25, 16'h0);
    send(2'd2, 5'd12, 5'd13, 5'd0, 6'h0, 16'h0044);
    idle();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    set_desc(2'd1, 5'd31, 5'd31, 5'd0, 6'h0, 16'hBEEF);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_addr !== 8'd0) begin
      n_err++;
      $display("FAIL reset_mid got vld=%b rdy=%b addr=%0d want 0 1 0",
               out_valid, in_ready, out_addr);
    end
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      n_chk++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL reset_no_ghost got vld=%b instr=%h want 0", out_valid, out_instr);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    set_desc(2'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0);
    in_valid = 1'b0;
    test_reset();
    test_lw();
    test_backpressure();
    test_illegal();
    test_stream();
    test_saturate();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
